// File: rtl/batcharger_ctrl.sv
// Charge controller FSM: IDLE/TC/CC/CV/DONE/PAUSE/FAULT, driven by debounced ADC
// thresholds, a per-state timer and a temperature window; all outputs registered.
module batcharger_ctrl #(
  parameter int                 VCUTOFF = 154,
  parameter int                 VPRESET = 215,
  parameter int                 VRECH   = 205,
  parameter int                 TMIN    = 40,
  parameter int                 TMAX    = 85,
  parameter int                 DEB     = 4,
  parameter int                 TIMER_W = 24,
  parameter logic [TIMER_W-1:0] TC_TMAX = 24'd1_000_000,
  parameter logic [TIMER_W-1:0] CV_TMAX = 24'd4_000_000
) (
  input  logic       clk,
  input  logic       rstz,
  input  logic       en,
  input  logic [3:0] sel,
  input  logic       adc_valid,
  input  logic [7:0] vbat,
  input  logic [8:0] ibat,
  input  logic [7:0] vtbat,
  output logic       tc,
  output logic       cc,
  output logic       cv,
  output logic       done,
  output logic       fault,
  output logic [8:0] iset,
  output logic [7:0] vset
);

  typedef enum logic [2:0] {
    S_IDLE, S_TC, S_CC, S_CV, S_DONE, S_PAUSE, S_FAULT
  } state_t;

  state_t             r_state;
  state_t             w_nxt;
  logic [TIMER_W-1:0] r_timer;
  logic [TIMER_W-1:0] w_tinc;
  logic [3:0]         r_deb;
  logic [3:0]         w_deb_inc;
  logic [4:0]         w_sel1;
  logic [8:0]         w_icc;
  logic [8:0]         w_itc;
  logic               w_tin;
  logic               w_qual;
  logic               w_fire;
  logic               w_tc_to;
  logic               w_cv_to;

  // itc and iend share the C/8 code
  assign w_sel1 = {1'b0, sel} + 5'd1;
  assign w_icc  = {w_sel1, 4'b0000};
  assign w_itc  = {3'b000, w_sel1, 1'b0};

  assign w_tin  = (vtbat >= 8'(TMIN)) && (vtbat <= 8'(TMAX));

  always_comb begin
    w_qual = 1'b0;
    case (r_state)
      S_TC:    w_qual = (vbat >= 8'(VCUTOFF));
      S_CC:    w_qual = (vbat >= 8'(VPRESET));
      S_CV:    w_qual = (ibat < w_itc);
      S_DONE:  w_qual = (vbat < 8'(VRECH));
      default: w_qual = 1'b0;
    endcase
  end

  assign w_deb_inc = (r_deb == 4'hF) ? r_deb : r_deb + 4'd1;
  assign w_fire    = adc_valid && w_qual && (w_deb_inc >= 4'(DEB));

  assign w_tinc  = (&r_timer) ? r_timer : r_timer + 1'b1;
  assign w_tc_to = (w_tinc >= TC_TMAX);
  assign w_cv_to = (w_tinc >= CV_TMAX);

  always_comb begin
    w_nxt = r_state;
    if (!en) begin
      w_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:
          if (adc_valid && w_tin) begin
            if (vbat < 8'(VCUTOFF))    w_nxt = S_TC;
            else if (vbat < 8'(VRECH)) w_nxt = S_CC;
            else                       w_nxt = S_DONE;
          end
        S_TC:
          if (adc_valid && !w_tin) w_nxt = S_PAUSE;
          else if (w_tc_to)        w_nxt = S_FAULT;
          else if (w_fire)         w_nxt = S_CC;
        S_CC:
          if (adc_valid && !w_tin) w_nxt = S_PAUSE;
          else if (w_fire)         w_nxt = S_CV;
        S_CV:
          if (adc_valid && !w_tin)  w_nxt = S_PAUSE;
          else if (w_cv_to || w_fire) w_nxt = S_DONE;
        S_DONE:
          if (w_fire) w_nxt = S_CC;
        S_PAUSE:
          if (adc_valid && w_tin) w_nxt = S_IDLE;
        S_FAULT:
          w_nxt = S_FAULT;
        default:
          w_nxt = S_IDLE;
      endcase
    end
  end

  // outputs decode the next state so they line up with the state register
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_deb   <= '0;
      tc      <= 1'b0;
      cc      <= 1'b0;
      cv      <= 1'b0;
      done    <= 1'b0;
      fault   <= 1'b0;
      iset    <= '0;
      vset    <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_nxt != r_state) begin
        r_timer <= '0;
        r_deb   <= '0;
      end else begin
        if (r_state == S_TC || r_state == S_CV) r_timer <= w_tinc;
        if (adc_valid) r_deb <= w_qual ? w_deb_inc : 4'd0;
      end
      tc    <= (w_nxt == S_TC);
      cc    <= (w_nxt == S_CC);
      cv    <= (w_nxt == S_CV);
      done  <= (w_nxt == S_DONE);
      fault <= (w_nxt == S_FAULT);
      iset  <= (w_nxt == S_TC) ? w_itc :
               (w_nxt == S_CC || w_nxt == S_CV) ? w_icc : 9'd0;
      vset  <= (w_nxt == S_CV) ? 8'(VPRESET) : 8'd0;
    end
  end

endmodule
